// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vend sequencer slice.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        VEND    = 2'b10,
        CHANGE  = 2'b11
    } vend_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Credit value of a coin code; zero marks an invalid code.
    function automatic logic [1:0] coin_to_credit(input logic [1:0] code);
        case (code)
            COIN_5:              return 2'd1;
            COIN_10:             return 2'd2;
            COIN_NONE, COIN_BAD: return 2'd0;
            default:             return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Idle timer for the COLLECT state; only instantiated with VEND_TIMEOUT_EN.
module vend_idle_timer
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] count;

    // Counts edges since the last accept, the accept edge itself being the first.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= TW'(1);
        end else if (run && !expired) begin
            count <= count + TW'(1);
        end
    end

    always_comb begin
        expired = run && (count >= TW'(TIMEOUT_CYC - 1));
    end

endmodule

// File: rtl/vend_sequencer.sv
// Coin-collect / vend / change sequencer. Optional COLLECT idle refund
// is enabled by defining VEND_TIMEOUT_EN.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_UNITS = 3,
    parameter int unsigned MAX_CREDIT  = 7,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               coin_valid,
    input  logic [1:0]                         coin_code,
    output logic                               coin_ready,
    input  logic                               cancel,
    output logic                               vend_req,
    input  logic                               vend_ack,
    output logic                               chg_valid,
    output logic [1:0]                         chg_code,
    input  logic                               chg_ready,
    output logic [$clog2(MAX_CREDIT+1)-1:0]    credit,
    output logic                               reject
);

    localparam int unsigned CW = $clog2(MAX_CREDIT + 1);
    localparam logic [CW:0]   PRICE_SUM = (CW+1)'(PRICE_UNITS);
    localparam logic [CW-1:0] PRICE_CR  = CW'(PRICE_UNITS);

    vend_state_t   state, state_next;
    logic [CW-1:0] credit_next;
    logic [CW:0]   coin_sum;
    logic [1:0]    coin_val;
    logic          accept, coin_ok, timeout, reject_next;

    assign coin_ready = !reset && ((state == IDLE) || (state == COLLECT));
    assign accept     = coin_valid && coin_ready;
    assign coin_val   = coin_to_credit(coin_code);
    assign coin_ok    = accept && (coin_val != 2'd0);
    assign coin_sum   = {1'b0, credit} + (CW+1)'(coin_val);

`ifdef VEND_TIMEOUT_EN
    logic timer_expired;

    vend_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept || (state != COLLECT)),
        .run     (state == COLLECT),
        .expired (timer_expired)
    );

    assign timeout = timer_expired && !accept;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            credit <= '0;
            reject <= 1'b0;
        end else begin
            state  <= state_next;
            credit <= credit_next;
            reject <= reject_next;
        end
    end

    always_comb begin
        state_next  = state;
        credit_next = credit;
        reject_next = accept && (coin_val == 2'd0);
        case (state)
            // A coin arriving with cancel is added first; reaching the price vends.
            IDLE, COLLECT: begin
                if (coin_ok) begin
                    credit_next = coin_sum[CW-1:0];
                    if (coin_sum >= PRICE_SUM) begin
                        state_next = VEND;
                    end else if (cancel) begin
                        state_next = CHANGE;
                    end else begin
                        state_next = COLLECT;
                    end
                end else if ((state == COLLECT) && (cancel || timeout)) begin
                    state_next = CHANGE;
                end
            end
            VEND: begin
                if (vend_ack) begin
                    credit_next = credit - PRICE_CR;
                    state_next  = (credit > PRICE_CR) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (credit == '0) begin
                    state_next = IDLE;
                end else if (chg_ready) begin
                    if (credit >= CW'(2)) begin
                        credit_next = credit - CW'(2);
                        state_next  = (credit == CW'(2)) ? IDLE : CHANGE;
                    end else begin
                        credit_next = credit - CW'(1);
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vend_req  = !reset && (state == VEND);
        chg_valid = !reset && (state == CHANGE);
        chg_code  = 2'b00;
        if (chg_valid) begin
            chg_code = (credit >= CW'(2)) ? COIN_10 : COIN_5;
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer; the idle-timeout case
// runs when VEND_TIMEOUT_EN is defined.
module tb_vend_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'b00;
    logic       coin_ready;
    logic       cancel = 1'b0;
    logic       vend_req;
    logic       vend_ack = 1'b0;
    logic       chg_valid;
    logic [1:0] chg_code;
    logic       chg_ready = 1'b0;
    logic [2:0] credit;
    logic       reject;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    vend_sequencer #(
        .PRICE_UNITS (3),
        .MAX_CREDIT  (7),
        .TIMEOUT_CYC (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .coin_ready (coin_ready),
        .cancel     (cancel),
        .vend_req   (vend_req),
        .vend_ack   (vend_ack),
        .chg_valid  (chg_valid),
        .chg_code   (chg_code),
        .chg_ready  (chg_ready),
        .credit     (credit),
        .reject     (reject)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        step();
        coin_valid = 1'b0;
        coin_code  = 2'b00;
    endtask

    initial begin
        // Reset behaviour
        step();
        chk("rst_coin_ready", 32'(coin_ready), 0);
        chk("rst_credit", 32'(credit), 0);
        chk("rst_vend_req", 32'(vend_req), 0);
        chk("rst_chg_valid", 32'(chg_valid), 0);
        chk("rst_chg_code", 32'(chg_code), 0);
        chk("rst_reject", 32'(reject), 0);
        reset = 1'b0;
        step();
        chk("idle_coin_ready", 32'(coin_ready), 1);

        // 5 then 10 reaches the price exactly
        coin(2'b01);
        chk("a_credit1", 32'(credit), 1);
        chk("a_vend_req0", 32'(vend_req), 0);
        coin(2'b10);
        chk("a_credit3", 32'(credit), 3);
        chk("a_vend_req1", 32'(vend_req), 1);
        chk("a_coin_ready0", 32'(coin_ready), 0);
        step();
        chk("a_vend_hold", 32'(vend_req), 1);
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        chk("a_credit0", 32'(credit), 0);
        chk("a_vend_done", 32'(vend_req), 0);
        chk("a_no_chg", 32'(chg_valid), 0);
        chk("a_coin_ready1", 32'(coin_ready), 1);

        // 10 + 10 leaves one five in change, held across stalls
        coin(2'b10);
        chk("b_credit2", 32'(credit), 2);
        coin(2'b10);
        chk("b_credit4", 32'(credit), 4);
        chk("b_vend_req", 32'(vend_req), 1);
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        chk("b_credit1", 32'(credit), 1);
        chk("b_chg_valid", 32'(chg_valid), 1);
        chk("b_chg_code", 32'(chg_code), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b_chg_hold_valid", 32'(chg_valid), 1);
            chk("b_chg_hold_code", 32'(chg_code), 1);
            chk("b_chg_hold_credit", 32'(credit), 1);
        end
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        chk("b_credit_end", 32'(credit), 0);
        chk("b_chg_done", 32'(chg_valid), 0);
        chk("b_idle", 32'(coin_ready), 1);

        // Cancel after a ten refunds one ten
        coin(2'b10);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("c_chg_valid", 32'(chg_valid), 1);
        chk("c_chg_code", 32'(chg_code), 2);
        chk("c_credit", 32'(credit), 2);
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        chk("c_credit0", 32'(credit), 0);
        chk("c_chg_done", 32'(chg_valid), 0);
        chk("c_idle", 32'(coin_ready), 1);

        // Invalid coins pulse reject and leave credit alone
        coin(2'b11);
        chk("d_reject_idle", 32'(reject), 1);
        chk("d_credit_idle", 32'(credit), 0);
        step();
        chk("d_reject_clear", 32'(reject), 0);
        coin(2'b01);
        coin(2'b11);
        chk("d_reject_coll", 32'(reject), 1);
        chk("d_credit_coll", 32'(credit), 1);
        // Stray handshakes are ignored while collecting
        vend_ack  = 1'b1;
        chg_ready = 1'b1;
        step();
        vend_ack  = 1'b0;
        chg_ready = 1'b0;
        chk("d_reject_once", 32'(reject), 0);
        chk("d_ignore_credit", 32'(credit), 1);
        chk("d_ignore_vend", 32'(vend_req), 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("d_refund_code", 32'(chg_code), 1);
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        chk("d_refund_done", 32'(credit), 0);

        // Coin and cancel together: refund below price, vend at price
        coin_valid = 1'b1;
        coin_code  = 2'b01;
        cancel     = 1'b1;
        step();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        chk("e_refund_valid", 32'(chg_valid), 1);
        chk("e_refund_code", 32'(chg_code), 1);
        chk("e_refund_credit", 32'(credit), 1);
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        chk("e_refund_done", 32'(credit), 0);
        coin(2'b01);
        coin_valid = 1'b1;
        coin_code  = 2'b10;
        cancel     = 1'b1;
        step();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        chk("e_vend_wins", 32'(vend_req), 1);
        chk("e_no_refund", 32'(chg_valid), 0);
        chk("e_vend_credit", 32'(credit), 3);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("e_cancel_in_vend", 32'(vend_req), 1);
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        chk("e_vend_done", 32'(credit), 0);

        // Reset during change discards the remaining credit
        coin(2'b10);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("f_in_change", 32'(chg_valid), 1);
        reset = 1'b1;
        step();
        chk("f_rst_credit", 32'(credit), 0);
        chk("f_rst_chg_valid", 32'(chg_valid), 0);
        chk("f_rst_chg_code", 32'(chg_code), 0);
        reset = 1'b0;
        step();
        chk("f_post_credit", 32'(credit), 0);
        chk("f_post_chg_valid", 32'(chg_valid), 0);
        chk("f_post_idle", 32'(coin_ready), 1);

`ifdef VEND_TIMEOUT_EN
        // Idle refund fires on the eighth cycle after the accept
        coin(2'b01);
        for (int i = 1; i < 8; i++) begin
            chk("g_wait_no_chg", 32'(chg_valid), 0);
            step();
        end
        chk("g_timeout_chg", 32'(chg_valid), 1);
        chk("g_timeout_code", 32'(chg_code), 1);
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        chk("g_timeout_done", 32'(credit), 0);
`else
        // Without the timer, COLLECT holds indefinitely
        coin(2'b01);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        chk("g_hold_chg", 32'(chg_valid), 0);
        chk("g_hold_credit", 32'(credit), 1);
        chk("g_hold_ready", 32'(coin_ready), 1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chg_ready = 1'b1;
        step();
        chg_ready = 1'b0;
        chk("g_cleanup", 32'(credit), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL provide parameter PRICE_UNITS, default 3, vend price in 5-unit credits.
REQ-002 SHALL provide parameter MAX_CREDIT, default 7, credit register limit; the legal range is MAX_CREDIT >= PRICE_UNITS+1.
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 1000, idle cycles in COLLECT before auto-refund.
REQ-004 SHALL have ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- coin_valid  in  1  coin acceptor presents a coin
- coin_code  in  2  01=5 (1 credit), 10=10 (2 credits), 00/11=invalid
- coin_ready  out  1  sequencer can accept a coin
- cancel  in  1  refund request, level-sampled
- vend_req  out  1  dispense request to motor
- vend_ack  in  1  dispense complete
- chg_valid  out  1  change coin request
- chg_code  out  2  10=ten, 01=five
- chg_ready  in  1  change dispenser accepts coin
- credit  out  $clog2(MAX_CREDIT+1)  current credit
- reject  out  1  one-cycle pulse on invalid coin

Function
REQ-005 SHALL implement states IDLE, COLLECT, VEND, CHANGE.
REQ-006 SHALL define a coin accept as coin_valid&&coin_ready in the same cycle.
REQ-007 SHALL drive coin_ready=1 only in IDLE and COLLECT.
REQ-008 SHALL, on a valid coin accept, add the coin value to credit, registered, visible the next cycle.
REQ-009 SHALL, on an invalid-code accept, leave credit unchanged and pulse reject for exactly one cycle.
REQ-010 SHALL go IDLE->COLLECT on the first valid coin; COLLECT->VEND in the cycle new credit >= PRICE_UNITS; a single coin may go IDLE->VEND directly.
REQ-011 SHALL hold vend_req=1 throughout VEND until vend_ack; on vend_ack, credit -= PRICE_UNITS, then go to CHANGE if the remainder is >0, else IDLE.
REQ-012 SHALL, in CHANGE, hold chg_valid=1 with chg_code=10 if credit>=2, else 01; on chg_ready, decrement credit by 2 or 1; go to IDLE once credit reaches 0.
REQ-013 SHALL, on cancel in COLLECT, go to CHANGE (full refund); cancel in IDLE, VEND, CHANGE SHALL be ignored.
REQ-014 SHALL, when a coin accept and cancel occur in the same cycle, add the coin first and refund the summed credit, unless the sum >= PRICE_UNITS, in which case VEND wins.
REQ-015 SHALL hold chg_code stable while chg_valid=1 and chg_ready=0.
REQ-016 SHALL ignore vend_ack outside VEND and chg_ready outside CHANGE.

Reset
REQ-017 SHALL, on reset, force state=IDLE, credit=0, coin_ready=0 for that cycle, and vend_req, chg_valid, chg_code=00, reject=0; the idle timer is cleared.
REQ-018 SHALL make reset in VEND or CHANGE discard the pending credit without refund.

Configuration
REQ-019 SHALL, with VEND_TIMEOUT_EN defined, count consecutive COLLECT cycles without a coin accept, restart the count on each accept, and force COLLECT->CHANGE when the count reaches TIMEOUT_CYC.
REQ-020 SHALL, without VEND_TIMEOUT_EN, contain no timer logic; COLLECT then exits only on a vend or on cancel.

Structure
REQ-021 SHALL place in package vend_pkg: the state enum type, the coin-code localparams (COIN_NONE/5/10/BAD), and a coin-to-credit function.
REQ-022 SHALL implement the timeout counter as sub-module vend_idle_timer (inputs: clear, run; output: expired), instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-023 Coins 01,10 with PRICE_UNITS=3 -> vend_req the cycle after the second accept; credit=0 after vend_ack; no chg_valid.
REQ-024 Coins 10,10 -> vend, then one chg_valid with chg_code=01 held across 3 chg_ready=0 cycles; IDLE after the handshake.
REQ-025 Coin 10, then cancel -> chg_code=10 once, credit=0, IDLE; coin 11 -> reject pulse, credit unchanged.
REQ-026 Coin 01 with cancel in the same cycle -> refund of 01; coin 10 + cancel at credit=1 -> VEND, not refund.
REQ-027 VEND_TIMEOUT_EN, TIMEOUT_CYC=8, one coin 01 -> chg_valid asserts 8 cycles after the accept.
REQ-028 Reset asserted during CHANGE with credit=2 -> the next cycle shows IDLE, credit=0, chg_valid=0.
